// File: rtl/tiny_tone_generator.sv
// tiny_tone_generator
//   Single-voice tone synthesizer with a 1-bit PWM audio output.
//   A write-only register file (8 x 5 bit) sets pitch, waveform, volume
//   and an ADSR envelope. The waveform sample is scaled by the envelope
//   and the volume into an 8-bit level that drives an 8-bit PWM.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous reset, ACTIVE-HIGH despite its name
//   ena             1 = run; 0 = freeze all state, drop writes, output 0
//   address_in      register address (3 bit)
//   write_strobe_in level-held write strobe; one write per rising edge
//   data_in         write data (5 bit)
//   signal_bit_out  registered PWM audio bit
//
// Register map
//   R0 period[4:0]   R1 period[9:5]   R2 [1:0] wave, [4] gate
//   R3 volume        R4 attack rate   R5 decay rate
//   R6 sustain level R7 release rate  (R3..R7 use bits [3:0])
module tiny_tone_generator #(
  parameter int PRESCALE     = 16,
  parameter int ENV_PRESCALE = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] address_in,
  input  logic       write_strobe_in,
  input  logic [4:0] data_in,
  output logic       signal_bit_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int EW = (ENV_PRESCALE > 1) ? $clog2(ENV_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST     = PW'(PRESCALE - 1);
  localparam logic [EW-1:0] ENV_PRE_LAST = EW'(ENV_PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } env_state_t;

  // ---------------------------------------------------------------------
  // Register file and strobe edge detect
  // ---------------------------------------------------------------------
  logic [4:0] r_regs [8];
  logic       r_strb_d;
  logic       w_write;

  // The strobe history keeps tracking while frozen, so a strobe that is
  // already high when ena returns does not produce a write.
  assign w_write = ena && write_strobe_in && !r_strb_d;

  // NOTE: the register file is small and must read as zero after reset, so
  // every entry is cleared explicitly; it is flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_strb_d <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      r_strb_d <= write_strobe_in;
      if (w_write) r_regs[address_in] <= data_in;
    end
  end

  logic [9:0] w_period;
  logic [1:0] w_wave;
  logic       w_gate;
  logic [3:0] w_volume, w_attack, w_decay, w_sustain, w_release;

  assign w_period  = {r_regs[1], r_regs[0]};
  assign w_wave    = r_regs[2][1:0];
  assign w_gate    = r_regs[2][4];
  assign w_volume  = r_regs[3][3:0];
  assign w_attack  = r_regs[4][3:0];
  assign w_decay   = r_regs[5][3:0];
  assign w_sustain = r_regs[6][3:0];
  assign w_release = r_regs[7][3:0];

  // ---------------------------------------------------------------------
  // Tone tick, pitch divider, step counter and noise LFSR
  // ---------------------------------------------------------------------
  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic [9:0]    r_div;
  logic [3:0]    r_step;
  logic [14:0]   r_lfsr;
  logic          w_adv;

  assign w_tick = ena && (r_pre == PRE_LAST);
  // ">=" rather than "==" so that lowering the period below the current
  // count wraps on the next tick instead of running to 1023.
  assign w_adv  = w_tick && (r_div >= w_period);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pre  <= '0;
      r_div  <= '0;
      r_step <= '0;
      r_lfsr <= 15'h0001;
    end else if (ena) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_div <= w_adv ? '0 : r_div + 1'b1;
      if (w_adv) begin
        r_step <= r_step + 1'b1;
        r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // ADSR envelope
  // ---------------------------------------------------------------------
  logic [EW-1:0] r_env_pre;
  logic          w_env_tick;
  env_state_t    r_state, w_state_next;
  logic [3:0]    r_env, w_env_next;
  logic [3:0]    r_rcnt, w_rcnt_next;
  logic          r_gate_d;
  logic          w_gate_rise;
  logic [3:0]    w_rate;
  logic          w_move;

  assign w_env_tick  = ena && (r_env_pre == ENV_PRE_LAST);
  assign w_gate_rise = w_gate && !r_gate_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_env_pre <= '0;
      r_state   <= S_IDLE;
      r_env     <= '0;
      r_rcnt    <= '0;
      r_gate_d  <= 1'b0;
    end else if (ena) begin
      r_env_pre <= w_env_tick ? '0 : r_env_pre + 1'b1;
      r_state   <= w_state_next;
      r_env     <= w_env_next;
      r_rcnt    <= w_rcnt_next;
      r_gate_d  <= w_gate;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_env_next   = r_env;
    w_rcnt_next  = r_rcnt;
    w_move       = 1'b0;

    unique case (r_state)
      S_ATTACK:  w_rate = w_attack;
      S_DECAY:   w_rate = w_decay;
      S_RELEASE: w_rate = w_release;
      default:   w_rate = 4'd0;
    endcase

    // Level moves once every (rate+1) envelope ticks.
    if (w_env_tick) begin
      if (r_rcnt >= w_rate) begin
        w_move      = 1'b1;
        w_rcnt_next = 4'd0;
      end else begin
        w_rcnt_next = r_rcnt + 1'b1;
      end
    end

    unique case (r_state)
      S_IDLE:
        if (w_gate_rise) w_state_next = S_ATTACK;
      S_ATTACK:
        if (!w_gate)              w_state_next = S_RELEASE;
        else if (r_env == 4'd15)  w_state_next = S_DECAY;
        else if (w_move)          w_env_next   = r_env + 1'b1;
      S_DECAY:
        if (!w_gate)                w_state_next = S_RELEASE;
        else if (r_env <= w_sustain) w_state_next = S_SUSTAIN;
        else if (w_move)            w_env_next   = r_env - 1'b1;
      S_SUSTAIN:
        if (!w_gate) w_state_next = S_RELEASE;
      S_RELEASE:
        if (w_gate_rise)         w_state_next = S_ATTACK;
        else if (r_env == 4'd0)  w_state_next = S_IDLE;
        else if (w_move)         w_env_next   = r_env - 1'b1;
      default:
        w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state) w_rcnt_next = 4'd0;
  end

  // ---------------------------------------------------------------------
  // Waveform, mixer and PWM
  // ---------------------------------------------------------------------
  logic [3:0]  w_sample;
  logic [7:0]  w_prod;
  logic [4:0]  w_vol_p1;
  logic [11:0] w_scaled;
  logic [7:0]  w_level;
  logic [7:0]  r_pwm_cnt;
  logic        r_out;

  always_comb begin
    unique case (w_wave)
      2'b00:   w_sample = r_step[3] ? 4'd15 : 4'd0;
      2'b01:   w_sample = r_step;
      2'b10:   w_sample = r_step[3] ? {~r_step[2:0], 1'b0} : {r_step[2:0], 1'b0};
      default: w_sample = r_lfsr[3:0];
    endcase
  end

  assign w_prod   = 8'(w_sample) * 8'(r_env);
  assign w_vol_p1 = {1'b0, w_volume} + 5'd1;
  // 225 * 16 = 3600 is the largest product, so 12 bits never overflow.
  assign w_scaled = 12'(w_prod) * 12'(w_vol_p1);
  assign w_level  = w_scaled[11:4];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pwm_cnt <= '0;
      r_out     <= 1'b0;
    end else if (ena) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_out     <= (r_pwm_cnt < w_level);
    end else begin
      r_out     <= 1'b0;
    end
  end

  assign signal_bit_out = r_out;

  // Stored-but-ignored register bits and the discarded product fraction.
  logic w_unused;
  assign w_unused = ^{r_regs[2][3:2], r_regs[3][4], r_regs[4][4], r_regs[5][4],
                      r_regs[6][4], r_regs[7][4], w_scaled[3:0]};

endmodule

// File: tb/tb_tiny_tone_generator.sv
// Self-checking bench for tiny_tone_generator. A behavioural model computes
// the expected PWM bit, envelope level, step and divider each clock from
// the register contents using plain integer arithmetic; a compare process
// checks the DUT against it every cycle, and directed sections add
// hand-computed expectations (duty counts, mix levels, ADSR timing).
module tb_tiny_tone_generator;

  localparam int PRE  = 16;
  localparam int EPRE = 4;

  localparam int ST_IDLE    = 0;
  localparam int ST_ATTACK  = 1;
  localparam int ST_DECAY   = 2;
  localparam int ST_SUSTAIN = 3;
  localparam int ST_RELEASE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [2:0] address_in = '0;
  logic       write_strobe_in = 1'b0;
  logic [4:0] data_in = '0;
  logic       signal_bit_out;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b1;

  tiny_tone_generator #(.PRESCALE(PRE), .ENV_PRESCALE(EPRE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .address_in      (address_in),
    .write_strobe_in (write_strobe_in),
    .data_in         (data_in),
    .signal_bit_out  (signal_bit_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  int m_regs[8];
  int m_strb_d, m_pre, m_div, m_step, m_lfsr, m_epre;
  int m_env, m_stage, m_rcnt, m_gate_d, m_pwm, m_out;
  int t_period, t_gate, t_level, t_tick, t_adv, t_etick;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_strb_d = 0; m_pre = 0; m_div = 0; m_step = 0; m_lfsr = 1; m_epre = 0;
    m_env = 0; m_stage = ST_IDLE; m_rcnt = 0; m_gate_d = 0; m_pwm = 0; m_out = 0;
  endtask

  function automatic int wave_of(input int wave, input int step, input int lfsr);
    case (wave)
      0: return (step >= 8) ? 15 : 0;
      1: return step;
      2: return (step < 8) ? 2 * step : 2 * (15 - step);
      default: return lfsr % 16;
    endcase
  endfunction

  task automatic m_envelope(input int gate, input int etick);
    int rate, rc, ns, ne, mv, rise;
    rate = (m_stage == ST_ATTACK)  ? m_regs[4] % 16 :
           (m_stage == ST_DECAY)   ? m_regs[5] % 16 :
           (m_stage == ST_RELEASE) ? m_regs[7] % 16 : 0;
    rc = m_rcnt; mv = 0;
    if (etick != 0) begin
      if (m_rcnt >= rate) begin mv = 1; rc = 0; end
      else rc = m_rcnt + 1;
    end
    ns = m_stage; ne = m_env;
    rise = (gate == 1 && m_gate_d == 0) ? 1 : 0;
    case (m_stage)
      ST_IDLE:    if (rise != 0) ns = ST_ATTACK;
      ST_ATTACK:  if (gate == 0) ns = ST_RELEASE;
                  else if (m_env == 15) ns = ST_DECAY;
                  else if (mv != 0) ne = m_env + 1;
      ST_DECAY:   if (gate == 0) ns = ST_RELEASE;
                  else if (m_env <= m_regs[6] % 16) ns = ST_SUSTAIN;
                  else if (mv != 0) ne = m_env - 1;
      ST_SUSTAIN: if (gate == 0) ns = ST_RELEASE;
      default:    if (rise != 0) ns = ST_ATTACK;
                  else if (m_env == 0) ns = ST_IDLE;
                  else if (mv != 0) ne = m_env - 1;
    endcase
    if (ns != m_stage) rc = 0;
    m_stage = ns; m_env = ne; m_rcnt = rc;
  endtask

  initial m_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      m_reset();
    end else begin
      t_period = m_regs[0] + 32 * m_regs[1];
      t_gate   = (m_regs[2] / 16) % 2;
      t_level  = wave_of(m_regs[2] % 4, m_step, m_lfsr) * m_env * (m_regs[3] % 16 + 1) / 16;
      if (ena) begin
        t_tick = (m_pre == PRE - 1) ? 1 : 0;
        m_pre  = (t_tick != 0) ? 0 : m_pre + 1;
        t_adv  = (t_tick != 0 && m_div >= t_period) ? 1 : 0;
        if (t_tick != 0) m_div = (t_adv != 0) ? 0 : m_div + 1;
        if (t_adv != 0) begin
          m_step = (m_step + 1) % 16;
          m_lfsr = ((m_lfsr * 2) + (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) % 32768;
        end
        t_etick = (m_epre == EPRE - 1) ? 1 : 0;
        m_epre  = (t_etick != 0) ? 0 : m_epre + 1;
        m_envelope(t_gate, t_etick);
        m_gate_d = t_gate;
        m_out = (m_pwm < t_level) ? 1 : 0;
        m_pwm = (m_pwm + 1) % 256;
        if (write_strobe_in && m_strb_d == 0) m_regs[address_in] = data_in;
      end else begin
        m_out = 0;
      end
      m_strb_d = write_strobe_in;
    end
  end

  // Per-cycle comparison, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("out", signal_bit_out, m_out);
      check("env", dut.r_env, m_env);
      check("step", dut.r_step, m_step);
      check("div", dut.r_div, m_div);
    end
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------
  task automatic wr(input int a, input int d);
    @(negedge clk);
    address_in = 3'(a); data_in = 5'(d); write_strobe_in = 1'b1;
    @(negedge clk);
    write_strobe_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      highs += int'(signal_bit_out);
    end
  endtask

  // which: 0 = model step, 1 = model stage, 2 = model env
  task automatic wait_model(input string name, input int which, input int target,
                            input int budget, output int cycles);
    int cur;
    cycles = 0;
    forever begin
      cur = (which == 0) ? m_step : (which == 1) ? m_stage : m_env;
      if (cur == target || cycles >= budget) break;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= budget) check({name, "_timeout"}, cycles, -1);
  endtask

  int highs, cyc;
  int snap_step, snap_div;
  int saw_step[3]  = '{8, 3, 15};
  int saw_level[3] = '{60, 22, 112};

  initial begin
    // Reset held
    repeat (5) @(negedge clk);
    check("reset_out", signal_bit_out, 0);
    check("reset_level", dut.w_level, 0);
    rst_n = 1'b0;

    // Idle after reset: silent
    count_high(10000, highs);
    check("idle_highs", highs, 0);

    // Strobe held 127 cycles with data changing mid-hold: one write only
    @(negedge clk);
    address_in = 3'd0; data_in = 5'd6; write_strobe_in = 1'b1;
    repeat (60) @(negedge clk);
    data_in = 5'd9;
    repeat (67) @(negedge clk);
    write_strobe_in = 1'b0;
    @(negedge clk);
    check("held_strobe_r0", dut.r_regs[0], 6);
    wr(0, 2);
    check("r0_rewrite", dut.r_regs[0], 2);
    @(negedge clk);
    data_in = 5'd6; write_strobe_in = 1'b1;
    @(negedge clk);
    write_strobe_in = 1'b0; data_in = 5'd13;
    @(negedge clk);
    check("pulse_strobe_r0", dut.r_regs[0], 6);

    // Square, period 6, full volume, instant attack/decay, sustain 15
    wr(1, 0); wr(3, 15); wr(4, 0); wr(5, 0); wr(6, 15); wr(7, 0);
    wr(2, 5'b10000);
    wait_model("attack", 2, 15, 200, cyc);
    check("attack_time_in_range", int'(cyc >= 52 && cyc <= 66), 1);
    check("attack_env", dut.r_env, 15);
    wait_model("sq_high", 0, 8, 2000, cyc);
    repeat (10) @(negedge clk);
    check("sq_level", dut.w_level, 225);
    count_high(256, highs);
    check("sq_high_duty", highs, 225);
    wait_model("sq_low", 0, 0, 2000, cyc);
    repeat (10) @(negedge clk);
    count_high(256, highs);
    check("sq_low_duty", highs, 0);

    // Saw, period 0, volume 7, env 15
    wr(0, 0); wr(3, 7); wr(2, 5'b10001);
    for (int i = 0; i < 3; i++) begin
      wait_model("saw_step", 0, saw_step[i], 400, cyc);
      check($sformatf("saw_level_step%0d", saw_step[i]), dut.w_level, saw_level[i]);
    end

    // Noise briefly, model-compared every cycle
    wr(2, 5'b10011);
    repeat (500) @(negedge clk);

    // Release from 15 at rate 0, then ADSR with sustain 8 and release 1
    wr(2, 5'b00011);
    wait_model("rel0_idle", 1, ST_IDLE, 300, cyc);
    wr(6, 8); wr(7, 1); wr(2, 5'b10001);
    wait_model("sustain", 1, ST_SUSTAIN, 400, cyc);
    check("sustain_env", dut.r_env, 8);
    wr(2, 5'b00001);
    wait_model("release", 2, 0, 200, cyc);
    check("release_time_in_range", int'(cyc >= 55 && cyc <= 72), 1);
    wait_model("rel1_idle", 1, ST_IDLE, 20, cyc);
    check("release_env", dut.r_env, 0);
    count_high(300, highs);
    check("idle_after_release_highs", highs, 0);

    // ena low mid-tone: frozen, silent, writes dropped, no burst on resume
    wr(3, 15); wr(0, 6); wr(2, 5'b10000);
    repeat (600) @(negedge clk);
    ena = 1'b0;
    snap_step = m_step;
    snap_div  = m_div;
    repeat (100) @(negedge clk);
    address_in = 3'd3; data_in = 5'd0; write_strobe_in = 1'b1;
    count_high(900, highs);
    check("frozen_highs", highs, 0);
    check("frozen_step", dut.r_step, snap_step);
    check("frozen_div", dut.r_div, snap_div);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    write_strobe_in = 1'b0;
    @(negedge clk);
    check("frozen_write_dropped", dut.r_regs[3], 15);
    repeat (300) @(negedge clk);

    // Reset mid-operation
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_out", signal_bit_out, 0);
    check("midreset_env", dut.r_env, 0);
    check("midreset_step", dut.r_step, 0);
    check("midreset_r2", dut.r_regs[2], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
